// File: rtl/branch_update_scheduler.sv
// ============================================================================
// Module   : branch_update_scheduler
// Purpose  : Queues EX branch resolutions and issues at most one predictor/BTB
//            update per cycle. Optional macro BUPD_BYPASS_EN adds a same-cycle
//            issue path when the queue is idle and empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_update_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_cond,
    input  logic                  in_taken,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_target,
    input  logic                  flush,
    output logic                  update_predictor,
    output logic                  update_btb,
    output logic                  actually_taken,
    output logic [DATA_WIDTH-1:0] resolved_pc,
    output logic [DATA_WIDTH-1:0] resolved_pc_target,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_ENTRY_W = 2 * DATA_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] c_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_ONE  = CNT_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [c_ENTRY_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [1:0]            r_state;
    logic                  r_upd_pred;
    logic                  r_upd_btb;
    logic                  r_taken;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_tgt;

    logic                  w_in_ready;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ENTRY_W-1:0]  w_head;

    assign w_in_ready = (r_count < c_FULL) && (r_state != c_FLUSH);

`ifdef BUPD_BYPASS_EN
    // IDLE implies an empty queue, so the incoming entry can go straight out.
    assign w_bypass = in_valid && (r_state == c_IDLE) && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && w_in_ready && !flush && !w_bypass;
    assign w_pop  = (r_state == c_DRAIN) && (r_count != '0) && !flush;
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_is_cond, in_taken, in_pc, in_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= c_IDLE;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= c_FLUSH;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            case (r_state)
                c_IDLE:  if (w_push) r_state <= c_DRAIN;
                c_DRAIN: if (w_pop && !w_push && (r_count == c_ONE)) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_pred <= 1'b0;
            r_upd_btb  <= 1'b0;
            r_taken    <= 1'b0;
            r_pc       <= '0;
            r_tgt      <= '0;
        end else if (w_pop) begin
            r_upd_pred <= w_head[c_ENTRY_W-1];
            r_upd_btb  <= w_head[c_ENTRY_W-2];
            r_taken    <= w_head[c_ENTRY_W-2];
            r_pc       <= w_head[2*DATA_WIDTH-1:DATA_WIDTH];
            r_tgt      <= w_head[DATA_WIDTH-1:0];
        end else begin
            r_upd_pred <= 1'b0;
            r_upd_btb  <= 1'b0;
            // A bypassed entry leaves its data on the outputs once issued.
            if (w_bypass) begin
                r_taken <= in_taken;
                r_pc    <= in_pc;
                r_tgt   <= in_target;
            end
        end
    end

    assign in_ready           = w_in_ready;
    assign count              = r_count;
    assign update_predictor   = w_bypass ? in_is_cond : r_upd_pred;
    assign update_btb         = w_bypass ? in_taken   : r_upd_btb;
    assign actually_taken     = w_bypass ? in_taken   : r_taken;
    assign resolved_pc        = w_bypass ? in_pc      : r_pc;
    assign resolved_pc_target = w_bypass ? in_target  : r_tgt;

endmodule

`default_nettype wire

// File: tb/tb_branch_update_scheduler.sv
// ============================================================================
// Module   : tb_branch_update_scheduler
// Purpose  : Directed and random stimulus against a queue-based reference model
//            of the branch update scheduler (default build, no bypass).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_update_scheduler;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 4;
    localparam int c_CW    = 3;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_is_cond;
    logic            in_taken;
    logic [c_DW-1:0] in_pc;
    logic [c_DW-1:0] in_target;
    logic            flush;
    logic            update_predictor;
    logic            update_btb;
    logic            actually_taken;
    logic [c_DW-1:0] resolved_pc;
    logic [c_DW-1:0] resolved_pc_target;
    logic [c_CW-1:0] count;

    branch_update_scheduler #(
        .DATA_WIDTH(c_DW),
        .DEPTH     (c_DEPTH),
        .CNT_WIDTH (c_CW)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_is_cond        (in_is_cond),
        .in_taken          (in_taken),
        .in_pc             (in_pc),
        .in_target         (in_target),
        .flush             (flush),
        .update_predictor  (update_predictor),
        .update_btb        (update_btb),
        .actually_taken    (actually_taken),
        .resolved_pc       (resolved_pc),
        .resolved_pc_target(resolved_pc_target),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            c;
        logic            t;
        logic [c_DW-1:0] pc;
        logic [c_DW-1:0] tg;
    } ent_t;

    ent_t            q[$];
    bit              m_flushing;
    bit              m_known;
    bit              m_acc;
    logic            m_pred, m_btb, m_tk;
    logic [c_DW-1:0] m_pc, m_tg;
    int              n_checks;
    int              n_fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input logic v, input logic c, input logic t,
                        input logic [c_DW-1:0] pc, input logic [c_DW-1:0] tg,
                        input logic fl, input logic r);
        bit   ready;
        ent_t e;
        in_valid   = v;
        in_is_cond = c;
        in_taken   = t;
        in_pc      = pc;
        in_target  = tg;
        flush      = fl;
        rst        = r;
        #1;
        ready = (q.size() < c_DEPTH) && !m_flushing;
        if (m_known) chk("in_ready", 64'(in_ready), 64'(ready));
        @(posedge clk);
        m_acc = 1'b0;
        if (r) begin
            q.delete();
            m_flushing = 1'b0;
            {m_pred, m_btb, m_tk, m_pc, m_tg} = '0;
        end else if (fl) begin
            q.delete();
            m_flushing = 1'b1;
            m_pred = 1'b0;
            m_btb  = 1'b0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                m_pred = e.c;
                m_btb  = e.t;
                m_tk   = e.t;
                m_pc   = e.pc;
                m_tg   = e.tg;
            end else begin
                m_pred = 1'b0;
                m_btb  = 1'b0;
            end
            if (v && ready) begin
                e.c = c; e.t = t; e.pc = pc; e.tg = tg;
                q.push_back(e);
                m_acc = 1'b1;
            end
            m_flushing = 1'b0;
        end
        m_known = 1'b1;
        #1;
        chk("update_predictor",   64'(update_predictor),   64'(m_pred));
        chk("update_btb",         64'(update_btb),         64'(m_btb));
        chk("actually_taken",     64'(actually_taken),     64'(m_tk));
        chk("resolved_pc",        64'(resolved_pc),        64'(m_pc));
        chk("resolved_pc_target", 64'(resolved_pc_target), 64'(m_tg));
        chk("count",              64'(count),              64'(q.size()));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        logic [c_DW-1:0] pc, tg;
        logic            c, t;
        n_checks   = 0;
        n_fails    = 0;
        m_known    = 1'b0;
        m_flushing = 1'b0;
        {in_valid, in_is_cond, in_taken, flush} = '0;
        in_pc = '0; in_target = '0; rst = 1'b1;

        // Reset held two cycles while EX presents a branch.
        step(1, 1, 1, 32'h50, 32'h60, 0, 1);
        step(1, 1, 1, 32'h50, 32'h60, 0, 1);
        idle(1);

        // Single conditional taken, then not-taken cond, then taken jal.
        step(1, 1, 1, 32'h100, 32'h140, 0, 0);
        idle(2);
        step(1, 1, 0, 32'h200, 32'h204, 0, 0);
        idle(1);
        step(1, 0, 1, 32'h300, 32'h380, 0, 0);
        idle(1);
        // Not-taken jal/jalr pops with both strobes low.
        step(1, 0, 0, 32'h310, 32'h314, 0, 0);
        idle(1);

        // Back-to-back burst; an unaccepted entry is held until taken.
        for (int i = 0; i < 6; ) begin
            step(1, i[0], 1'b1, 32'h400 + 32'(i * 4), 32'h800 + 32'(i * 4), 0, 0);
            if (m_acc) i++;
        end
        idle(3);

        // Flush with concurrent in_valid, then pushes during the flush cycle.
        step(1, 1, 1, 32'h500, 32'h504, 0, 0);
        step(1, 1, 1, 32'h510, 32'h514, 1, 0);
        step(1, 1, 1, 32'h520, 32'h524, 0, 0);
        idle(2);

        // Reset in the middle of draining.
        step(1, 1, 1, 32'h600, 32'h604, 0, 0);
        step(1, 0, 1, 32'h610, 32'h614, 0, 0);
        step(1, 1, 0, 32'h620, 32'h624, 0, 1);
        idle(3);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            c  = 1'($urandom);
            t  = 1'($urandom);
            pc = $urandom;
            tg = $urandom;
            step(($urandom % 4) != 0, c, t, pc, tg,
                 ($urandom % 23) == 0, ($urandom % 61) == 0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
